writeback_stage: RTL and testbench

- MEM/WB stage and the write-port driver of the register file: produces the write flag, destination address and write data that the register file consumes.
- Accepts one retiring instruction per handshake from MEM and waits for a delayed data-memory load response when needed.
- Selects and extends the result (ALU / load / PC+4), suppresses x0 writes, faults misaligned loads, and handles flush.

---
 rtl/riscv_wb_pkg.sv | 21 ++
 rtl/load_extend.sv | 44 ++++
 rtl/writeback_stage.sv | 166 ++++++++++++++++
 tb/tb_writeback_stage.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the MEM/WB stage:
// result-select codes, load Funct3 codes and FSM states.
package riscv_wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension,
// plus misaligned / illegal load-type detection.
module load_extend
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o,
  output logic            fault_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{offset_i, 3'b000} +: 8];
  assign half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Pick the lane and extend it according to the load type
  always_comb begin
    data_o  = '0;
    fault_o = 1'b0;
    unique case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_LH: begin
        fault_o = offset_i[0];
        data_o  = {{(XLEN-16){half_s[15]}}, half_s};
      end
      F3_LHU: begin
        fault_o = offset_i[0];
        data_o  = {{(XLEN-16){1'b0}}, half_s};
      end
      F3_LW: begin
        fault_o = |offset_i;
        data_o  = word_i;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: retires one instruction per handshake and
// drives the register-file write port, waiting on loads.
module writeback_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               Clk_In,
  input  logic               Reset_n_In,
  input  logic               Mem_Valid_In,
  output logic               Mem_Ready_Out,
  input  logic               Flush_In,
  input  logic               Reg_Write_flag_In,
  input  logic [RADDR_W-1:0] RD_Addr_In,
  input  logic [1:0]         WB_Sel_In,
  input  logic [2:0]         Funct3_In,
  input  logic [1:0]         Byte_Offset_In,
  input  logic [XLEN-1:0]    ALU_Result_In,
  input  logic [XLEN-1:0]    PC_Plus4_In,
  input  logic               Load_Rsp_Valid_In,
  input  logic [XLEN-1:0]    Load_Rsp_Data_In,
  output logic               Reg_Write_flag_Out,
  output logic [RADDR_W-1:0] RD_Addr_Out,
  output logic [XLEN-1:0]    RD_Data_Out,
  output logic               Retire_Out,
  output logic               Load_Fault_Out
);

  wb_state_e state_q, state_d;

  logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic               ld_wr_q, ld_wr_d;
  logic [2:0]         ld_f3_q, ld_f3_d;
  logic [1:0]         ld_off_q, ld_off_d;

  logic               wr_q, wr_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               ret_q, ret_d;
  logic               flt_q, flt_d;

  logic            run;
  logic            accept;
  logic [2:0]      ext_f3;
  logic [1:0]      ext_off;
  logic [XLEN-1:0] ext_data;
  logic            ext_fault;

  assign run           = (state_q == ST_RUN);
  assign Mem_Ready_Out = Reset_n_In && run;
  assign accept        = Mem_Valid_In && Mem_Ready_Out;

  // Fault check uses live inputs at accept, the
  // captured load type while waiting for the response.
  assign ext_f3  = run ? Funct3_In      : ld_f3_q;
  assign ext_off = run ? Byte_Offset_In : ld_off_q;

  load_extend #(
    .XLEN(XLEN)
  ) u_ext (
    .funct3_i(ext_f3),
    .offset_i(ext_off),
    .word_i  (Load_Rsp_Data_In),
    .data_o  (ext_data),
    .fault_o (ext_fault)
  );

  // Next state, load capture and write-port values
  always_comb begin
    state_d  = state_q;
    ld_rd_d  = ld_rd_q;
    ld_wr_d  = ld_wr_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    wr_d     = 1'b0;
    ret_d    = 1'b0;
    flt_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      ST_RUN: begin
        if (accept && !Flush_In) begin
          if (WB_Sel_In == WB_SEL_LOAD) begin
            if (ext_fault) begin
              flt_d = 1'b1;
              ret_d = 1'b1;
            end else begin
              ld_rd_d  = RD_Addr_In;
              ld_wr_d  = Reg_Write_flag_In
                         && (RD_Addr_In != '0);
              ld_f3_d  = Funct3_In;
              ld_off_d = Byte_Offset_In;
              state_d  = ST_WAIT;
            end
          end else begin
            ret_d = 1'b1;
            wr_d  = Reg_Write_flag_In
                    && (RD_Addr_In != '0);
            if (wr_d) begin
              addr_d = RD_Addr_In;
              case (WB_Sel_In)
                WB_SEL_ALU: data_d = ALU_Result_In;
                WB_SEL_PC4: data_d = PC_Plus4_In;
                default:    data_d = ALU_Result_In;
              endcase
            end
          end
        end
      end
      ST_WAIT: begin
        if (Load_Rsp_Valid_In) begin
          state_d = ST_RUN;
          if (!Flush_In) begin
            ret_d = 1'b1;
            wr_d  = ld_wr_q;
            if (ld_wr_q) begin
              addr_d = ld_rd_q;
              data_d = ext_data;
            end
          end
        end else if (Flush_In) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (Load_Rsp_Valid_In) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge Clk_In) begin
    if (!Reset_n_In) begin
      state_q  <= ST_RUN;
      ld_rd_q  <= '0;
      ld_wr_q  <= 1'b0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ret_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_rd_q  <= ld_rd_d;
      ld_wr_q  <= ld_wr_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ret_q    <= ret_d;
      flt_q    <= flt_d;
    end
  end

  assign Reg_Write_flag_Out = wr_q;
  assign RD_Addr_Out        = addr_q;
  assign RD_Data_Out        = data_q;
  assign Retire_Out         = ret_q;
  assign Load_Fault_Out     = flt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage
// against a behavioural writeback/load model.
module tb_writeback_stage;

  logic        Clk_In = 1'b0;
  logic        Reset_n_In;
  logic        Mem_Valid_In;
  logic        Mem_Ready_Out;
  logic        Flush_In;
  logic        Reg_Write_flag_In;
  logic [4:0]  RD_Addr_In;
  logic [1:0]  WB_Sel_In;
  logic [2:0]  Funct3_In;
  logic [1:0]  Byte_Offset_In;
  logic [31:0] ALU_Result_In;
  logic [31:0] PC_Plus4_In;
  logic        Load_Rsp_Valid_In;
  logic [31:0] Load_Rsp_Data_In;
  logic        Reg_Write_flag_Out;
  logic [4:0]  RD_Addr_Out;
  logic [31:0] RD_Data_Out;
  logic        Retire_Out;
  logic        Load_Fault_Out;

  writeback_stage dut (
    .Clk_In            (Clk_In),
    .Reset_n_In        (Reset_n_In),
    .Mem_Valid_In      (Mem_Valid_In),
    .Mem_Ready_Out     (Mem_Ready_Out),
    .Flush_In          (Flush_In),
    .Reg_Write_flag_In (Reg_Write_flag_In),
    .RD_Addr_In        (RD_Addr_In),
    .WB_Sel_In         (WB_Sel_In),
    .Funct3_In         (Funct3_In),
    .Byte_Offset_In    (Byte_Offset_In),
    .ALU_Result_In     (ALU_Result_In),
    .PC_Plus4_In       (PC_Plus4_In),
    .Load_Rsp_Valid_In (Load_Rsp_Valid_In),
    .Load_Rsp_Data_In  (Load_Rsp_Data_In),
    .Reg_Write_flag_Out(Reg_Write_flag_Out),
    .RD_Addr_Out       (RD_Addr_Out),
    .RD_Data_Out       (RD_Data_Out),
    .Retire_Out        (Retire_Out),
    .Load_Fault_Out    (Load_Fault_Out)
  );

  always #5 Clk_In = ~Clk_In;

  // {write, retire, fault, ready}
  wire [3:0] obs = {Reg_Write_flag_Out, Retire_Out,
                    Load_Fault_Out, Mem_Ready_Out};

  int errs   = 0;
  int checks = 0;

  // Last value written to the register file
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic tick;
    @(posedge Clk_In);
    #1;
  endtask

  task automatic idle;
    Mem_Valid_In      = 1'b0;
    Flush_In          = 1'b0;
    Load_Rsp_Valid_In = 1'b0;
  endtask

  // Expected load result from the ISA rules
  task automatic ref_load(input logic [2:0] f3,
                          input logic [1:0] off,
                          input logic [31:0] w,
                          output logic f,
                          output logic [31:0] d);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    f = 1'b0;
    d = '0;
    case (f3)
      3'd0: d = (b >= 128) ? b - 256 : b;
      3'd4: d = b;
      3'd1: if (off % 2 != 0) f = 1'b1;
            else d = (h >= 32768) ? h - 65536 : h;
      3'd5: if (off % 2 != 0) f = 1'b1;
            else d = h;
      3'd2: if (off != 0) f = 1'b1;
            else d = w;
      default: f = 1'b1;
    endcase
  endtask

  task automatic test_reset;
    idle();
    Reg_Write_flag_In = 0; RD_Addr_In = 0;
    WB_Sel_In = 0; Funct3_In = 0;
    Byte_Offset_In = 0; ALU_Result_In = 0;
    PC_Plus4_In = 0; Load_Rsp_Data_In = 0;
    Reset_n_In = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 4'b0000 || RD_Addr_Out !== 5'd0
        || RD_Data_Out !== 32'd0)
      $display("FAIL reset_state: obs=%b a=%0d d=%h exp 0000/0/0",
               obs, RD_Addr_Out, RD_Data_Out);
    if (obs !== 4'b0000 || RD_Addr_Out !== 5'd0
        || RD_Data_Out !== 32'd0) errs++;
    Reset_n_In = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0001) begin
      errs++;
      $display("FAIL reset_release: obs=%b exp 0001", obs);
    end
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic test_alu_back_to_back;
    for (int i = 0; i < 40; i++) begin
      logic v, fl, fw, ew;
      logic [1:0] sel;
      logic [4:0] rd;
      logic [31:0] alu, pc;
      logic [3:0] eo;
      int s;
      v = 1; fl = 0; pc = $urandom;
      case (i)
        0: begin sel = 2'b00; rd = 5; fw = 1;
                 alu = 32'h12345678; end
        1: begin sel = 2'b00; rd = 0; fw = 1;
                 alu = 32'hDEADBEEF; end
        2: begin sel = 2'b10; rd = 1; fw = 1;
                 alu = 32'h0; pc = 32'h1004; end
        3: begin sel = 2'b11; rd = 31; fw = 1;
                 alu = 32'hCAFE0001; end
        default: begin
          v   = ($urandom_range(0, 4) != 0);
          s   = $urandom_range(0, 2);
          sel = (s == 0) ? 2'b00 : (s == 1) ? 2'b10 : 2'b11;
          rd  = 5'($urandom);
          fw  = 1'($urandom);
          fl  = ($urandom_range(0, 5) == 0);
          alu = $urandom;
        end
      endcase
      checks++;
      if (Mem_Ready_Out !== 1'b1) begin
        errs++;
        $display("FAIL alu_ready: ready=%b exp 1", Mem_Ready_Out);
      end
      Mem_Valid_In = v; Flush_In = fl; WB_Sel_In = sel;
      RD_Addr_In = rd; Reg_Write_flag_In = fw;
      ALU_Result_In = alu; PC_Plus4_In = pc;
      Funct3_In = 3'($urandom); Byte_Offset_In = 2'($urandom);
      Load_Rsp_Valid_In = 1'($urandom);
      Load_Rsp_Data_In = $urandom;
      tick();
      eo = 4'b0001;
      if (v && !fl) begin
        ew = fw && (rd != 0);
        eo = {ew, 3'b101};
        if (ew) begin
          m_addr = rd;
          m_data = (sel == 2'b10) ? pc : alu;
        end
      end
      checks++;
      if (obs !== eo) begin
        errs++;
        $display("FAIL alu_outs[%0d]: obs=%b exp %b", i, obs, eo);
      end
      checks++;
      if (RD_Addr_Out !== m_addr || RD_Data_Out !== m_data) begin
        errs++;
        $display("FAIL alu_data[%0d]: a=%0d d=%h exp a=%0d d=%h",
                 i, RD_Addr_Out, RD_Data_Out, m_addr, m_data);
      end
    end
    idle();
    tick();
    checks++;
    if (obs !== 4'b0001) begin
      errs++;
      $display("FAIL alu_idle: obs=%b exp 0001", obs);
    end
  endtask

  task automatic do_load(input logic [2:0] f3,
                         input logic [1:0] off,
                         input logic [31:0] word,
                         input int dly,
                         input logic [4:0] rd,
                         input logic fw,
                         input logic same);
    logic ef, ew;
    logic [31:0] ed;
    ref_load(f3, off, word, ef, ed);
    Mem_Valid_In = 1; Flush_In = 0; WB_Sel_In = 2'b01;
    Funct3_In = f3; Byte_Offset_In = off;
    RD_Addr_In = rd; Reg_Write_flag_In = fw;
    ALU_Result_In = $urandom; PC_Plus4_In = $urandom;
    Load_Rsp_Valid_In = same; Load_Rsp_Data_In = ~word;
    tick();
    Mem_Valid_In = 0;
    Load_Rsp_Valid_In = 0;
    checks++;
    if (ef) begin
      if (obs !== 4'b0111) begin
        errs++;
        $display("FAIL ld_fault f3=%0d off=%0d: obs=%b exp 0111",
                 f3, off, obs);
      end
    end else begin
      if (obs !== 4'b0000) begin
        errs++;
        $display("FAIL ld_accept f3=%0d: obs=%b exp 0000",
                 f3, obs);
      end
      for (int i = 1; i < dly; i++) begin
        Load_Rsp_Data_In = $urandom;
        tick();
        checks++;
        if (obs !== 4'b0000) begin
          errs++;
          $display("FAIL ld_wait: obs=%b exp 0000", obs);
        end
      end
      Load_Rsp_Valid_In = 1;
      Load_Rsp_Data_In = word;
      tick();
      Load_Rsp_Valid_In = 0;
      ew = fw && (rd != 0);
      if (ew) begin
        m_addr = rd;
        m_data = ed;
      end
      checks++;
      if (obs !== {ew, 3'b101}) begin
        errs++;
        $display("FAIL ld_done f3=%0d: obs=%b exp %b",
                 f3, obs, {ew, 3'b101});
      end
    end
    checks++;
    if (RD_Addr_Out !== m_addr || RD_Data_Out !== m_data) begin
      errs++;
      $display("FAIL ld_data f3=%0d off=%0d: a=%0d d=%h exp a=%0d d=%h",
               f3, off, RD_Addr_Out, RD_Data_Out, m_addr, m_data);
    end
  endtask

  task automatic test_load;
    do_load(3'd0, 2'd3, 32'h80FF0000, 3, 5'd10, 1, 0);
    do_load(3'd4, 2'd3, 32'h80FF0000, 3, 5'd11, 1, 0);
    do_load(3'd5, 2'd2, 32'h80FF0000, 3, 5'd12, 1, 0);
    do_load(3'd1, 2'd1, 32'h80FF0000, 3, 5'd13, 1, 0);
    do_load(3'd2, 2'd2, 32'h11223344, 1, 5'd14, 1, 0);
    do_load(3'd3, 2'd0, 32'h11223344, 1, 5'd15, 1, 0);
    do_load(3'd2, 2'd0, 32'hA5A5F00D, 1, 5'd16, 1, 1);
    do_load(3'd1, 2'd2, 32'h8001FFFF, 2, 5'd0, 1, 0);
    for (int i = 0; i < 40; i++)
      do_load(3'($urandom), 2'($urandom), $urandom,
              $urandom_range(1, 4), 5'($urandom),
              1'($urandom), 1'($urandom));
  endtask

  task automatic test_flush;
    // Accept with flush in RUN is dropped
    Mem_Valid_In = 1; Flush_In = 1; WB_Sel_In = 2'b00;
    RD_Addr_In = 7; Reg_Write_flag_In = 1;
    ALU_Result_In = 32'h77777777;
    tick();
    Mem_Valid_In = 0; Flush_In = 0;
    checks++;
    if (obs !== 4'b0001 || RD_Data_Out !== m_data) begin
      errs++;
      $display("FAIL flush_run_alu: obs=%b d=%h exp 0001 d=%h",
               obs, RD_Data_Out, m_data);
    end
    // Flushed legal load must not start a wait
    Mem_Valid_In = 1; Flush_In = 1; WB_Sel_In = 2'b01;
    Funct3_In = 3'd2; Byte_Offset_In = 0;
    tick();
    Mem_Valid_In = 0; Flush_In = 0;
    Load_Rsp_Valid_In = 1; Load_Rsp_Data_In = 32'h99999999;
    checks++;
    if (obs !== 4'b0001) begin
      errs++;
      $display("FAIL flush_run_load: obs=%b exp 0001", obs);
    end
    tick();
    Load_Rsp_Valid_In = 0;
    checks++;
    if (obs !== 4'b0001 || RD_Data_Out !== m_data) begin
      errs++;
      $display("FAIL rsp_in_run: obs=%b d=%h exp 0001 d=%h",
               obs, RD_Data_Out, m_data);
    end
    // Load, flush one cycle later, response two after that
    Mem_Valid_In = 1; RD_Addr_In = 8; Reg_Write_flag_In = 1;
    tick();
    Mem_Valid_In = 0;
    checks++;
    if (obs !== 4'b0000) begin
      errs++;
      $display("FAIL drain_accept: obs=%b exp 0000", obs);
    end
    Flush_In = 1;
    tick();
    Flush_In = 0;
    checks++;
    if (obs !== 4'b0000) begin
      errs++;
      $display("FAIL drain_enter: obs=%b exp 0000", obs);
    end
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      errs++;
      $display("FAIL drain_hold: obs=%b exp 0000", obs);
    end
    Load_Rsp_Valid_In = 1; Load_Rsp_Data_In = 32'h88888888;
    tick();
    Load_Rsp_Valid_In = 0;
    checks++;
    if (obs !== 4'b0001 || RD_Data_Out !== m_data) begin
      errs++;
      $display("FAIL drain_done: obs=%b d=%h exp 0001 d=%h",
               obs, RD_Data_Out, m_data);
    end
    // Flush and response together in WAIT_LOAD
    Mem_Valid_In = 1; RD_Addr_In = 9;
    tick();
    Mem_Valid_In = 0;
    Flush_In = 1; Load_Rsp_Valid_In = 1;
    Load_Rsp_Data_In = 32'h66666666;
    tick();
    Flush_In = 0; Load_Rsp_Valid_In = 0;
    checks++;
    if (obs !== 4'b0001 || RD_Data_Out !== m_data) begin
      errs++;
      $display("FAIL flush_with_rsp: obs=%b d=%h exp 0001 d=%h",
               obs, RD_Data_Out, m_data);
    end
    do_load(3'd2, 2'd0, 32'h0BADF00D, 2, 5'd20, 1, 0);
  endtask

  task automatic test_reset_wait;
    Mem_Valid_In = 1; Flush_In = 0; WB_Sel_In = 2'b01;
    Funct3_In = 3'd2; Byte_Offset_In = 0;
    RD_Addr_In = 9; Reg_Write_flag_In = 1;
    tick();
    Mem_Valid_In = 0;
    checks++;
    if (obs !== 4'b0000) begin
      errs++;
      $display("FAIL rstw_accept: obs=%b exp 0000", obs);
    end
    Reset_n_In = 0;
    tick();
    m_addr = '0;
    m_data = '0;
    Reset_n_In = 1;
    Load_Rsp_Valid_In = 1; Load_Rsp_Data_In = 32'h55AA55AA;
    #1;
    checks++;
    if (obs !== 4'b0001 || RD_Addr_Out !== 5'd0
        || RD_Data_Out !== 32'd0) begin
      errs++;
      $display("FAIL rstw_release: obs=%b a=%0d d=%h exp 0001/0/0",
               obs, RD_Addr_Out, RD_Data_Out);
    end
    tick();
    Load_Rsp_Valid_In = 0;
    checks++;
    if (obs !== 4'b0001 || RD_Addr_Out !== 5'd0
        || RD_Data_Out !== 32'd0) begin
      errs++;
      $display("FAIL rstw_late_rsp: obs=%b a=%0d d=%h exp 0001/0/0",
               obs, RD_Addr_Out, RD_Data_Out);
    end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_load();
    test_flush();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
